// File: rtl/alu_secuencial.sv
// Multi-cycle handshaked ALU: latches operands, runs mul/div/mod one bit per cycle,
// and holds the registered result and flags until the consumer takes them.
module alu_secuencial #(
  parameter int ANCHO = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             entrada_valida,
  output logic             entrada_lista,
  input  logic [ANCHO-1:0] operandoA,
  input  logic [ANCHO-1:0] operandoB,
  input  logic [3:0]       seleccion,
  output logic             salida_valida,
  input  logic             salida_lista,
  output logic [ANCHO-1:0] resultado,
  output logic [3:0]       banderas
);

  // state     | meaning
  // LIBRE     | waiting for operands, entrada_lista high
  // CALCULO   | latched operation in progress (1 or ANCHO cycles)
  // RESULTADO | result held until salida_lista
  localparam int CW = $clog2(ANCHO) + 1;
  localparam logic [CW-1:0] ULTIMA = CW'(ANCHO - 1);

  typedef enum logic [1:0] {LIBRE, CALCULO, RESULTADO} estado_t;

  estado_t              estado, estado_sig;
  logic [ANCHO-1:0]     op_a, op_b;
  logic [3:0]           op_sel;
  logic [CW-1:0]        cnt;
  logic [2*ANCHO-1:0]   acc, acc_sig;
  logic                 listo;
  logic [ANCHO-1:0]     res_sig;
  logic                 c_sig, v_sig;
  logic [3:0]           flags_sig;

  logic [ANCHO:0]       suma, resta, desp_izq, desp_der, prueba;
  logic [ANCHO-1:0]     b_desp, resto_div;
  logic [2*ANCHO-1:0]   parcial, acc_div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= LIBRE;
    else        estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      LIBRE:     if (entrada_valida) estado_sig = CALCULO;
      CALCULO:   if (listo)          estado_sig = RESULTADO;
      RESULTADO: if (salida_lista)   estado_sig = LIBRE;
      default:                       estado_sig = LIBRE;
    endcase
  end

  assign entrada_lista = (estado == LIBRE);
  assign salida_valida = (estado == RESULTADO);

  always_comb begin
    suma     = {1'b0, op_a} + {1'b0, op_b};
    resta    = {1'b0, op_a} - {1'b0, op_b};
    desp_izq = {1'b0, op_a} << op_b;
    desp_der = {op_a, 1'b0} >> op_b;
    b_desp   = op_b >> cnt;
    parcial  = b_desp[0] ? ({{ANCHO{1'b0}}, op_a} << cnt) : '0;
    // restoring step: acc = {remainder, dividend bits still to consume / quotient bits}
    prueba    = {acc[2*ANCHO-1:ANCHO], acc[ANCHO-1]};
    resto_div = prueba[ANCHO-1:0] - op_b;
    if (prueba >= {1'b0, op_b}) acc_div = {resto_div, acc[ANCHO-2:0], 1'b1};
    else                        acc_div = {prueba[ANCHO-1:0], acc[ANCHO-2:0], 1'b0};

    acc_sig = acc;
    listo   = 1'b1;
    res_sig = '0;
    c_sig   = 1'b0;
    v_sig   = 1'b0;
    case (op_sel)
      4'd0: begin
        res_sig = suma[ANCHO-1:0];
        c_sig   = suma[ANCHO];
        v_sig   = (op_a[ANCHO-1] == op_b[ANCHO-1]) && (suma[ANCHO-1] != op_a[ANCHO-1]);
      end
      4'd1: begin
        res_sig = resta[ANCHO-1:0];
        c_sig   = resta[ANCHO];
        v_sig   = (op_a[ANCHO-1] != op_b[ANCHO-1]) && (resta[ANCHO-1] != op_a[ANCHO-1]);
      end
      4'd2: begin
        acc_sig = acc + parcial;
        listo   = (cnt == ULTIMA);
        res_sig = acc_sig[ANCHO-1:0];
        v_sig   = |acc_sig[2*ANCHO-1:ANCHO];
      end
      4'd3, 4'd4: begin
        if (op_b == '0) begin
          res_sig = (op_sel == 4'd3) ? '1 : op_a;
          v_sig   = 1'b1;
        end else begin
          acc_sig = acc_div;
          listo   = (cnt == ULTIMA);
          res_sig = (op_sel == 4'd3) ? acc_div[ANCHO-1:0] : acc_div[2*ANCHO-1:ANCHO];
        end
      end
      4'd5: res_sig = op_a & op_b;
      4'd6: res_sig = op_a | op_b;
      4'd7: res_sig = op_a ^ op_b;
      4'd8: begin
        res_sig = desp_izq[ANCHO-1:0];
        c_sig   = desp_izq[ANCHO];
      end
      4'd9: begin
        res_sig = desp_der[ANCHO:1];
        c_sig   = desp_der[0];
      end
      default: res_sig = '0;
    endcase
    flags_sig = {res_sig[ANCHO-1], (res_sig == '0), c_sig, v_sig};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a      <= '0;
      op_b      <= '0;
      op_sel    <= '0;
      cnt       <= '0;
      acc       <= '0;
      resultado <= '0;
      banderas  <= '0;
    end else begin
      case (estado)
        LIBRE: begin
          if (entrada_valida) begin
            op_a   <= operandoA;
            op_b   <= operandoB;
            op_sel <= seleccion;
            cnt    <= '0;
            acc    <= (seleccion == 4'd2) ? '0 : {{ANCHO{1'b0}}, operandoA};
          end
        end
        CALCULO: begin
          acc <= acc_sig;
          if (listo) begin
            resultado <= res_sig;
            banderas  <= flags_sig;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_secuencial.sv
// Directed-vector bench for alu_secuencial (ANCHO=4): results, flags, latency,
// backpressure and mid-operation reset.
module tb_alu_secuencial;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       entrada_valida = 1'b0;
  logic       entrada_lista;
  logic [3:0] operandoA = '0;
  logic [3:0] operandoB = '0;
  logic [3:0] seleccion = '0;
  logic       salida_valida;
  logic       salida_lista = 1'b0;
  logic [3:0] resultado;
  logic [3:0] banderas;

  int n_vec = 0;
  int n_err = 0;

  alu_secuencial #(.ANCHO(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .entrada_valida(entrada_valida), .entrada_lista(entrada_lista),
    .operandoA(operandoA), .operandoB(operandoB), .seleccion(seleccion),
    .salida_valida(salida_valida), .salida_lista(salida_lista),
    .resultado(resultado), .banderas(banderas)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // hold > 0 keeps salida_lista low that many cycles while offering a competing operation
  task automatic run_op(input string tag, input logic [3:0] sel, input logic [3:0] a,
                        input logic [3:0] b, input int lat, input logic [3:0] r,
                        input logic [3:0] f, input int hold);
    int n;
    n = 0;
    while (!entrada_lista && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, " lista"}, entrada_lista, 1);
    seleccion = sel; operandoA = a; operandoB = b; entrada_valida = 1'b1;
    @(posedge clk); #1;
    entrada_valida = 1'b0;
    check({tag, " ocupado"}, entrada_lista, 0);
    n = 0;
    while (!salida_valida && n < 40) begin @(posedge clk); #1; n++; end
    check({tag, " latencia"}, n, lat);
    check({tag, " res"}, resultado, r);
    check({tag, " flags"}, banderas, f);
    for (int i = 0; i < hold; i++) begin
      seleccion = 4'd0; operandoA = 4'd1; operandoB = 4'd1; entrada_valida = 1'b1;
      @(posedge clk); #1;
      check({tag, " hold res"}, resultado, r);
      check({tag, " hold flags"}, banderas, f);
      check({tag, " hold valida"}, salida_valida, 1);
      check({tag, " hold lista"}, entrada_lista, 0);
    end
    entrada_valida = 1'b0;
    salida_lista = 1'b1;
    @(posedge clk); #1;
    salida_lista = 1'b0;
    check({tag, " consumido"}, salida_valida, 0);
    check({tag, " libre"}, entrada_lista, 1);
  endtask

  initial begin
    int vistos;
    #1;
    check("reset res", resultado, 0);
    check("reset flags", banderas, 0);
    check("reset valida", salida_valida, 0);
    check("reset lista", entrada_lista, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    //      tag         sel    A        B        lat res      flags {N,Z,C,V}
    run_op("add 7+9",   4'd0,  4'd7,    4'd9,    1,  4'b0000, 4'b0110, 0);
    run_op("sub 3-5",   4'd1,  4'd3,    4'd5,    1,  4'b1110, 4'b1010, 0);
    run_op("add 7+1",   4'd0,  4'd7,    4'd1,    1,  4'b1000, 4'b1001, 0);
    run_op("mul 6*3",   4'd2,  4'd6,    4'd3,    4,  4'b0010, 4'b0001, 0);
    run_op("mul 3*5",   4'd2,  4'd3,    4'd5,    4,  4'b1111, 4'b1000, 0);
    run_op("div 13/4",  4'd3,  4'd13,   4'd4,    4,  4'b0011, 4'b0000, 0);
    run_op("mod 13%4",  4'd4,  4'd13,   4'd4,    4,  4'b0001, 4'b0000, 0);
    run_op("div 13/0",  4'd3,  4'd13,   4'd0,    1,  4'b1111, 4'b1001, 0);
    run_op("mod 13%0",  4'd4,  4'd13,   4'd0,    1,  4'b1101, 4'b1001, 0);
    run_op("and",       4'd5,  4'b1100, 4'b1010, 1,  4'b1000, 4'b1000, 0);
    run_op("or",        4'd6,  4'b0100, 4'b0010, 1,  4'b0110, 4'b0000, 0);
    run_op("xor",       4'd7,  4'b1010, 4'b1010, 1,  4'b0000, 4'b0100, 0);
    run_op("shl 1001,1",4'd8,  4'b1001, 4'd1,    1,  4'b0010, 4'b0010, 0);
    run_op("shl 0011,0",4'd8,  4'b0011, 4'd0,    1,  4'b0011, 4'b0000, 0);
    run_op("shr 1001,4",4'd9,  4'b1001, 4'd4,    1,  4'b0000, 4'b0110, 0);
    run_op("shr 1010,1",4'd9,  4'b1010, 4'd1,    1,  4'b0101, 4'b0000, 0);
    run_op("shl 1111,9",4'd8,  4'b1111, 4'd9,    1,  4'b0000, 4'b0100, 0);
    run_op("opcode 12", 4'd12, 4'd5,    4'd3,    1,  4'b0000, 4'b0100, 0);
    run_op("sub 8-1 V", 4'd1,  4'd8,    4'd1,    1,  4'b0111, 4'b0001, 0);
    run_op("bp mul 3*5",4'd2,  4'd3,    4'd5,    4,  4'b1111, 4'b1000, 5);

    // mid-operation reset of a multiply
    seleccion = 4'd2; operandoA = 4'd6; operandoB = 4'd3; entrada_valida = 1'b1;
    @(posedge clk); #1;
    entrada_valida = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst res", resultado, 0);
    check("rst flags", banderas, 0);
    check("rst valida", salida_valida, 0);
    check("rst lista", entrada_lista, 1);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    vistos = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (salida_valida) vistos++;
    end
    check("rst sin resultado", vistos, 0);
    run_op("tras rst div 9/2", 4'd3, 4'd9, 4'd2, 4, 4'b0100, 4'b0000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
